// File: rtl/arbitro_rom.sv
// ROM read-bus arbiter: two four-phase rq/ack requesters share one ROM port.
// Optional build macro ARBITRO_ROM_ROUND_ROBIN_EN selects round-robin tie-breaking.
module arbitro_rom #(
    parameter int unsigned N_ATTESA = 2
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        rq0,
    input  logic [23:0] a0,
    output logic        ack0,
    output logic [7:0]  dato0,
    input  logic        rq1,
    input  logic [23:0] a1,
    output logic        ack1,
    output logic [7:0]  dato1,
    output logic [23:0] a23_a0,
    output logic        s_,
    output logic        mr_,
    input  logic [7:0]  d7_d0
);

    localparam int unsigned CW = (N_ATTESA > 1) ? $clog2(N_ATTESA) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N_ATTESA - 1);

    typedef enum logic [1:0] {StAttesaRq, StAccesso, StFine} stato_t;

    stato_t        stato;
    logic [CW-1:0] cnt;
    logic          ultimo;  // last granted requester; also the owner of the current transaction
    logic          sel;
    logic          any_rq;
    logic          rq_granted;

    always_comb begin
        any_rq     = rq0 | rq1;
        rq_granted = ultimo ? rq1 : rq0;
        if (rq0 && rq1) begin
`ifdef ARBITRO_ROM_ROUND_ROBIN_EN
            sel = ~ultimo;
`else
            sel = 1'b0;
`endif
        end else begin
            sel = rq1;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            stato  <= StAttesaRq;
            cnt    <= '0;
            ultimo <= 1'b1;
            a23_a0 <= 24'h000000;
            s_     <= 1'b1;
            mr_    <= 1'b1;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            dato0  <= 8'h00;
            dato1  <= 8'h00;
        end else begin
            unique case (stato)
                StAttesaRq: begin
                    if (any_rq) begin
                        a23_a0 <= sel ? a1 : a0;
                        s_     <= 1'b0;
                        mr_    <= 1'b0;
                        cnt    <= CNT_INIT;
                        ultimo <= sel;
                        stato  <= StAccesso;
                    end
                end
                StAccesso: begin
                    if (cnt == '0) begin
                        if (ultimo) begin
                            dato1 <= d7_d0;
                            ack1  <= 1'b1;
                        end else begin
                            dato0 <= d7_d0;
                            ack0  <= 1'b1;
                        end
                        s_    <= 1'b1;
                        mr_   <= 1'b1;
                        stato <= StFine;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StFine: begin
                    if (!rq_granted) begin
                        if (ultimo) begin
                            ack1 <= 1'b0;
                        end else begin
                            ack0 <= 1'b0;
                        end
                        stato <= StAttesaRq;
                    end
                end
                default: stato <= StAttesaRq;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_rom.sv
// Directed bench for arbitro_rom: main DUT with N_ATTESA=2, second DUT with N_ATTESA=1.
module tb_arbitro_rom;

    localparam int unsigned NW = 2;

    logic        clock;
    logic        reset_;
    logic        rq0, rq1;
    logic [23:0] a0, a1;
    logic        ack0, ack1;
    logic [7:0]  dato0, dato1;
    logic [23:0] a23_a0;
    logic        s_, mr_;
    wire  [7:0]  d7_d0;

    logic        rqb0, rqb1;
    logic [23:0] ab0, ab1;
    logic        ackb0, ackb1;
    logic [7:0]  datob0, datob1;
    logic [23:0] ab;
    logic        sb_, mrb_;
    wire  [7:0]  db;

    int passed;
    int total;

    function automatic logic [7:0] rom_byte(input logic [23:0] addr);
        if (addr == 24'hFF0002) return 8'h41;
        if (addr == 24'hFF000B) return 8'h7A;
        return addr[7:0] ^ 8'hA5;
    endfunction

    assign d7_d0 = (!s_ && !mr_) ? rom_byte(a23_a0) : 8'hzz;
    assign db    = (!sb_ && !mrb_) ? rom_byte(ab) : 8'hzz;

    arbitro_rom #(.N_ATTESA(NW)) dut (
        .clock(clock), .reset_(reset_),
        .rq0(rq0), .a0(a0), .ack0(ack0), .dato0(dato0),
        .rq1(rq1), .a1(a1), .ack1(ack1), .dato1(dato1),
        .a23_a0(a23_a0), .s_(s_), .mr_(mr_), .d7_d0(d7_d0)
    );

    arbitro_rom #(.N_ATTESA(1)) dut1 (
        .clock(clock), .reset_(reset_),
        .rq0(rqb0), .a0(ab0), .ack0(ackb0), .dato0(datob0),
        .rq1(rqb1), .a1(ab1), .ack1(ackb1), .dato1(datob1),
        .a23_a0(ab), .s_(sb_), .mr_(mrb_), .d7_d0(db)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        #2;
        reset_ = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        total++;
        if ({s_, mr_, ack0, ack1} !== 4'b1100) $display("FAIL reset_ctrl got=%b want=1100", {s_, mr_, ack0, ack1});
        else passed++;
        total++;
        if ({a23_a0, dato0, dato1} !== 40'h0) $display("FAIL reset_data got=%h want=0", {a23_a0, dato0, dato1});
        else passed++;
    endtask

    task automatic test_single();
        rq0 = 1'b1; a0 = 24'hFF0002;
        tick();  // grant edge
        total++;
        if ({s_, mr_, ack0, a23_a0} !== {3'b000, 24'hFF0002}) $display("FAIL single_grant got=%b%b%b %h want=000 ff0002", s_, mr_, ack0, a23_a0);
        else passed++;
        tick();
        total++;
        if ({s_, mr_, ack0} !== 3'b000) $display("FAIL single_hold got=%b%b%b want=000", s_, mr_, ack0);
        else passed++;
        tick();
        total++;
        if ({s_, mr_, ack0, dato0} !== {3'b111, 8'h41}) $display("FAIL single_ack got=%b%b%b %h want=111 41", s_, mr_, ack0, dato0);
        else passed++;
        tick();
        total++;
        if ({ack0, dato0} !== {1'b1, 8'h41}) $display("FAIL single_ack_hold got=%b %h want=1 41", ack0, dato0);
        else passed++;
        rq0 = 1'b0;
        tick();
        total++;
        if ({ack0, dato0, s_} !== {1'b0, 8'h41, 1'b1}) $display("FAIL single_ack_fall got=%b %h %b want=0 41 1", ack0, dato0, s_);
        else passed++;
    endtask

    task automatic test_tie_from_reset();
        do_reset();
        rq0 = 1'b1; rq1 = 1'b1; a0 = 24'hFF0002; a1 = 24'hFF000B;
        tick();
        total++;
        if (a23_a0 !== 24'hFF0002) $display("FAIL tie_first_addr got=%h want=ff0002", a23_a0);
        else passed++;
        repeat (NW) tick();
        total++;
        if ({ack0, dato0, ack1, dato1} !== {1'b1, 8'h41, 1'b0, 8'h00}) $display("FAIL tie_first_ack got=%b %h %b %h want=1 41 0 00", ack0, dato0, ack1, dato1);
        else passed++;
        rq0 = 1'b0;
        tick();
        total++;
        if ({ack0, ack1} !== 2'b00) $display("FAIL tie_ack0_fall got=%b%b want=00", ack0, ack1);
        else passed++;
        tick();
        total++;
        if ({s_, a23_a0, ack1} !== {1'b0, 24'hFF000B, 1'b0}) $display("FAIL tie_second_grant got=%b %h %b want=0 ff000b 0", s_, a23_a0, ack1);
        else passed++;
        repeat (NW) tick();
        total++;
        if ({ack1, dato1, ack0, dato0} !== {1'b1, 8'h7A, 1'b0, 8'h41}) $display("FAIL tie_second_ack got=%b %h %b %h want=1 7a 0 41", ack1, dato1, ack0, dato0);
        else passed++;
        rq1 = 1'b0;
        tick();
        total++;
        if (ack1 !== 1'b0) $display("FAIL tie_ack1_fall got=%b want=0", ack1);
        else passed++;
    endtask

    task automatic test_repeated_ties();
        logic [3:0] exp_win;
        logic       win;
`ifdef ARBITRO_ROM_ROUND_ROBIN_EN
        exp_win = 4'b1010;  // bit i = winner of tie i: 0,1,0,1
`else
        exp_win = 4'b0000;
`endif
        do_reset();
        a0 = 24'hFF0002; a1 = 24'hFF000B;
        rq0 = 1'b1; rq1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            win = (a23_a0 == 24'hFF000B);
            total++;
            if (win !== exp_win[i]) $display("FAIL tie_winner_%0d got=%b want=%b", i, win, exp_win[i]);
            else passed++;
            repeat (NW) tick();
            total++;
            if ((exp_win[i] ? ack1 : ack0) !== 1'b1) $display("FAIL tie_ack_%0d got=%b%b want ack%0d=1", i, ack1, ack0, exp_win[i]);
            else passed++;
            if (exp_win[i]) rq1 = 1'b0; else rq0 = 1'b0;
            tick();
            if (i < 3) begin
                rq0 = 1'b1; rq1 = 1'b1;
            end
        end
        rq0 = 1'b0; rq1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_early_drop();
        rq1 = 1'b1; a1 = 24'hFF000B;
        tick();
        tick();
        rq1 = 1'b0;
        repeat (NW - 1) tick();
        total++;
        if ({ack1, dato1, s_} !== {1'b1, 8'h7A, 1'b1}) $display("FAIL early_ack got=%b %h %b want=1 7a 1", ack1, dato1, s_);
        else passed++;
        tick();
        total++;
        if (ack1 !== 1'b0) $display("FAIL early_pulse got=%b want=0", ack1);
        else passed++;
        tick();
        total++;
        if ({s_, ack0, ack1} !== 3'b100) $display("FAIL early_idle got=%b%b%b want=100", s_, ack0, ack1);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rq0 = 1'b1; a0 = 24'hFF0002;
        tick();
        total++;
        if (s_ !== 1'b0) $display("FAIL mid_pre got=%b want=0", s_);
        else passed++;
        #2 reset_ = 1'b0;
        #1;
        total++;
        if ({s_, mr_, ack0, ack1, dato0, dato1, a23_a0} !== {4'b1100, 40'h0}) $display("FAIL mid_async got=%b%b%b%b %h %h %h want=1100 00 00 000000", s_, mr_, ack0, ack1, dato0, dato1, a23_a0);
        else passed++;
        #1 reset_ = 1'b1;
        tick();
        total++;
        if ({s_, a23_a0} !== {1'b0, 24'hFF0002}) $display("FAIL mid_regrant got=%b %h want=0 ff0002", s_, a23_a0);
        else passed++;
        repeat (NW) tick();
        total++;
        if ({ack0, dato0} !== {1'b1, 8'h41}) $display("FAIL mid_serve got=%b %h want=1 41", ack0, dato0);
        else passed++;
        rq0 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_n1();
        rqb0 = 1'b1; ab0 = 24'hFF0002;
        tick();
        total++;
        if ({sb_, ackb0} !== 2'b00) $display("FAIL n1_grant got=%b%b want=00", sb_, ackb0);
        else passed++;
        tick();
        total++;
        if ({ackb0, datob0, sb_} !== {1'b1, 8'h41, 1'b1}) $display("FAIL n1_ack got=%b %h %b want=1 41 1", ackb0, datob0, sb_);
        else passed++;
        rqb0 = 1'b0;
        tick();
        total++;
        if (ackb0 !== 1'b0) $display("FAIL n1_fall got=%b want=0", ackb0);
        else passed++;
        rqb0 = 1'b1; ab0 = 24'hFF000B;
        tick();
        total++;
        if ({sb_, ab} !== {1'b0, 24'hFF000B}) $display("FAIL n1_regrant got=%b %h want=0 ff000b", sb_, ab);
        else passed++;
        tick();
        total++;
        if ({ackb0, datob0} !== {1'b1, 8'h7A}) $display("FAIL n1_ack2 got=%b %h want=1 7a", ackb0, datob0);
        else passed++;
        rqb0 = 1'b0;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset_ = 1'b0;
        rq0 = 1'b0; rq1 = 1'b0; a0 = '0; a1 = '0;
        rqb0 = 1'b0; rqb1 = 1'b0; ab0 = '0; ab1 = '0;
        tick();
        test_reset();
        do_reset();
        test_single();
        test_tie_from_reset();
        test_repeated_ties();
        test_early_drop();
        test_reset_mid();
        test_back_to_back_n1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
